// File: rtl/conv3x3_kernel.sv
`default_nettype none
// ============================================================================
// conv3x3_kernel: 3-stage pipelined 3x3 convolution with programmable
// signed coefficients, fixed normalising shift and 8-bit saturation.
// Revision: 1.0
// ============================================================================
module conv3x3_kernel #(
  parameter int NORM_SHIFT  = 4,
  parameter int PIPE_STAGES = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [71:0] i_data,
  output logic        o_ready,
  input  logic        i_coef_wr,
  input  logic [3:0]  i_coef_addr,
  input  logic [7:0]  i_coef_data,
  output logic        o_valid,
  output logic [7:0]  o_data,
  input  logic        i_ready
);

  if (PIPE_STAGES != 3) begin : g_pipe_stages_check
    $error("conv3x3_kernel: PIPE_STAGES must be 3");
  end

  logic signed [7:0]  coef_q [9];
  logic signed [7:0]  coef_d [9];
  logic signed [16:0] prod_q [9];
  logic signed [16:0] prod_d [9];
  logic signed [18:0] row_q  [3];
  logic signed [18:0] row_d  [3];
  logic               v1_q, v1_d;
  logic               v2_q, v2_d;
  logic [7:0]         o_data_q, o_data_d;
  logic               o_valid_q, o_valid_d;
  logic               en;
  logic signed [20:0] total;
  logic signed [20:0] shifted;

  assign en      = !o_valid_q || i_ready;
  assign o_ready = en;
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;

  // Addresses 9..15 never match an index, so they are dropped silently.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      coef_d[i] = coef_q[i];
      if (i_coef_wr && (i_coef_addr == 4'(i))) begin
        coef_d[i] = i_coef_data;
      end
    end
  end

  always_comb begin
    v1_d = v1_q;
    for (int k = 0; k < 9; k++) begin
      prod_d[k] = prod_q[k];
    end
    if (en) begin
      v1_d = i_valid;
      for (int k = 0; k < 9; k++) begin
        prod_d[k] = $signed({9'b0, i_data[k*8 +: 8]}) *
                    $signed({{9{coef_q[k][7]}}, coef_q[k]});
      end
    end
  end

  always_comb begin
    v2_d = v2_q;
    for (int r = 0; r < 3; r++) begin
      row_d[r] = row_q[r];
    end
    if (en) begin
      v2_d = v1_q;
      for (int r = 0; r < 3; r++) begin
        row_d[r] = {{2{prod_q[r*3][16]}},   prod_q[r*3]}
                 + {{2{prod_q[r*3+1][16]}}, prod_q[r*3+1]}
                 + {{2{prod_q[r*3+2][16]}}, prod_q[r*3+2]};
      end
    end
  end

  // Arithmetic shift floors toward minus infinity before clamping.
  always_comb begin
    total   = {{2{row_q[0][18]}}, row_q[0]}
            + {{2{row_q[1][18]}}, row_q[1]}
            + {{2{row_q[2][18]}}, row_q[2]};
    shifted = total >>> NORM_SHIFT;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    if (en) begin
      o_valid_d = v2_q;
      if (v2_q) begin
        if (shifted[20]) begin
          o_data_d = 8'h00;
        end else if (shifted > 21'sd255) begin
          o_data_d = 8'hFF;
        end else begin
          o_data_d = shifted[7:0];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 9; i++) begin
        coef_q[i] <= (i == 4) ? 8'sd16 : 8'sd0;
        prod_q[i] <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        row_q[r] <= '0;
      end
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= 8'h00;
    end else begin
      for (int i = 0; i < 9; i++) begin
        coef_q[i] <= coef_d[i];
        prod_q[i] <= prod_d[i];
      end
      for (int r = 0; r < 3; r++) begin
        row_q[r] <= row_d[r];
      end
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_kernel.sv
`default_nettype none
// ============================================================================
// tb_conv3x3_kernel: directed and randomized bench with a scoreboard model.
// Revision: 1.0
// ============================================================================
module tb_conv3x3_kernel;
  localparam int NORM_SHIFT = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic [71:0] i_data;
  logic        o_ready;
  logic        i_coef_wr;
  logic [3:0]  i_coef_addr;
  logic [7:0]  i_coef_data;
  logic        o_valid;
  logic [7:0]  o_data;
  logic        i_ready;

  int checks = 0;
  int errors = 0;
  int model_coef [9];
  int exp_q [$];
  bit prev_hold = 1'b0;
  logic [7:0] prev_data;

  conv3x3_kernel #(.NORM_SHIFT(NORM_SHIFT), .PIPE_STAGES(3)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .i_coef_wr(i_coef_wr), .i_coef_addr(i_coef_addr),
    .i_coef_data(i_coef_data), .o_valid(o_valid), .o_data(o_data),
    .i_ready(i_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer dot product, floor shift, clamp to 0..255.
  function automatic int ref_pixel(input logic [71:0] w);
    int sum = 0;
    for (int k = 0; k < 9; k++) sum += int'(w[k*8 +: 8]) * model_coef[k];
    sum = sum >>> NORM_SHIFT;
    if (sum < 0) return 0;
    if (sum > 255) return 255;
    return sum;
  endfunction

  function automatic logic [71:0] win(input logic [7:0] centre, input logic [7:0] other);
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = (k == 4) ? centre : other;
    return w;
  endfunction

  // Scoreboard: decisions made at negedge reflect what the next posedge does.
  always @(negedge i_clk) begin
    if (i_reset) begin
      exp_q.delete();
      for (int k = 0; k < 9; k++) model_coef[k] = (k == 4) ? 16 : 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", o_valid, 1);
        check("hold_data", o_data, prev_data);
      end
      check("ready_rule", o_ready, (!o_valid || i_ready));
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) check("spurious_out", o_valid, 0);
        else check("sb_data", o_data, exp_q.pop_front());
      end
      if (i_valid && o_ready) exp_q.push_back(ref_pixel(i_data));
      if (i_coef_wr && i_coef_addr <= 4'd8)
        model_coef[i_coef_addr] = int'($signed(i_coef_data));
      prev_hold = o_valid && !i_ready;
      prev_data = o_data;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic write_coef(input logic [3:0] a, input logic [7:0] d);
    i_coef_wr = 1'b1; i_coef_addr = a; i_coef_data = d;
    tick();
    i_coef_wr = 1'b0;
  endtask

  task automatic send(input logic [71:0] w);
    int n = 0;
    i_valid = 1'b1; i_data = w;
    #1;
    while (!o_ready && n < 50) begin tick(); n++; end
    if (n >= 50) check("send_timeout", n, 0);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!o_valid && cyc < 20) begin tick(); cyc++; end
    if (cyc >= 20) check("wait_timeout", cyc, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n, sent, got, stall, first_c, last_c;
    i_reset = 1'b1; i_valid = 1'b0; i_data = '0; i_coef_wr = 1'b0;
    i_coef_addr = '0; i_coef_data = '0; i_ready = 1'b1;
    repeat (3) tick();
    i_reset = 1'b0;
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 8'h00);
    check("rst_ready", o_ready, 1);

    // Identity pass-through and latency
    send(win(8'h5A, 8'hFF));
    wait_valid(cyc);
    check("t1_latency", cyc + 1, 3);
    check("t1_data", o_data, 8'h5A);
    check("t1_ready", o_ready, 1);
    tick();

    // Box filter
    for (int k = 0; k < 9; k++) write_coef(4'(k), 8'd1);
    send(win(8'h10, 8'h10)); wait_valid(cyc); check("t2_box10", o_data, 8'h09); tick();
    send(win(8'hFF, 8'hFF)); wait_valid(cyc); check("t2_boxFF", o_data, 8'h8F); tick();

    // Saturation both ways
    for (int k = 0; k < 9; k++) write_coef(4'(k), 8'd0);
    write_coef(4'd4, 8'hF0);
    send(win(8'h20, 8'h00)); wait_valid(cyc); check("t3_sat_neg", o_data, 8'h00); tick();
    write_coef(4'd4, 8'd127);
    send(win(8'hFF, 8'h00)); wait_valid(cyc); check("t3_sat_pos", o_data, 8'hFF); tick();
    write_coef(4'd4, 8'd16);

    // Backpressure on the first output
    sent = 0; got = 0; stall = 0; first_c = 0; last_c = 0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      i_valid = (sent < 6);
      i_data  = win(8'(sent + 1), 8'h00);
      if (o_valid && got == 0 && stall < 4) begin i_ready = 1'b0; stall++; end
      else i_ready = 1'b1;
      #1;
      if (!i_ready) begin
        check("t4_stall_ready", o_ready, 0);
        check("t4_stall_data", o_data, 8'h01);
      end
      if (o_valid && i_ready) begin
        check("t4_order", o_data, got + 1);
        if (got == 0) first_c = c;
        last_c = c;
        got++;
      end
      if (i_valid && o_ready) sent++;
      tick();
    end
    i_valid = 1'b0; i_ready = 1'b1;
    check("t4_count", got, 6);
    check("t4_no_gaps", last_c - first_c, 5);

    // Coefficient write racing an accept
    i_valid = 1'b1; i_data = win(8'h10, 8'hFF);
    i_coef_wr = 1'b1; i_coef_addr = 4'd4; i_coef_data = 8'd32;
    #1 check("t5_ready", o_ready, 1);
    tick();
    i_coef_wr = 1'b0;
    tick();
    i_valid = 1'b0;
    wait_valid(cyc);
    check("t5_first", o_data, 8'h10);
    tick();
    check("t5_second_valid", o_valid, 1);
    check("t5_second", o_data, 8'h20);
    tick();
    write_coef(4'd12, 8'h7F);
    send(win(8'h10, 8'hFF)); wait_valid(cyc); check("t5_addr12", o_data, 8'h20); tick();
    write_coef(4'd4, 8'd16);

    // Reset with three windows in flight plus a coincident coefficient write
    write_coef(4'd4, 8'd32);
    write_coef(4'd0, 8'd1);
    i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin i_data = win(8'(8'h40 + k), 8'h00); tick(); end
    i_valid = 1'b0; i_reset = 1'b1;
    i_coef_wr = 1'b1; i_coef_addr = 4'd4; i_coef_data = 8'h7F;
    tick();
    i_reset = 1'b0; i_coef_wr = 1'b0;
    check("t6_valid_after_reset", o_valid, 0);
    n = 0;
    repeat (6) begin if (o_valid) n++; tick(); end
    check("t6_no_stale", n, 0);
    send(win(8'h33, 8'hFF));
    wait_valid(cyc);
    check("t6_latency", cyc + 1, 3);
    check("t6_identity", o_data, 8'h33);
    tick();

    // Randomized traffic against the scoreboard
    for (int c = 0; c < 400; c++) begin
      i_valid     = ($urandom_range(0, 3) != 0);
      i_data      = 72'({$urandom(), $urandom(), $urandom()});
      i_ready     = ($urandom_range(0, 9) < 7);
      i_coef_wr   = ($urandom_range(0, 9) == 0);
      i_coef_addr = 4'($urandom_range(0, 15));
      i_coef_data = 8'($urandom_range(0, 48)) - 8'd8;
      tick();
    end
    i_valid = 1'b0; i_coef_wr = 1'b0; i_ready = 1'b1;
    repeat (10) tick();
    check("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
